// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetch with one outstanding request, PC-tagged FIFO and redirect flush
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic [2:0]  fifo_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] FULL = 3'(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   state_t state, state_nx;
   logic [31:0] fetch_pc;
   logic [31:0] fifo_pc [DEPTH];
   logic [31:0] fifo_ins [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [2:0] count;
   logic push, pop;
   assign instr_valid = count != 3'd0;
   assign instr       = instr_valid ? fifo_ins[rd_ptr] : '0;
   assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;
   assign fifo_count  = count;
   assign imem_addr   = imem_req ? fetch_pc : '0;
   // handshake decode and next state; rst_n gates the request so it stays low while reset is held
   always_comb begin
      pop      = instr_valid & instr_ready & ~redirect;
      push     = (state == WAIT) & imem_rvalid & ~redirect;
      imem_req = rst_n & (state == IDLE) & ~redirect & ((count != FULL) | pop);
      state_nx = state;
      if (state == IDLE) state_nx = imem_req ? WAIT : IDLE;
      else if (imem_rvalid) state_nx = IDLE;
      else if (redirect) state_nx = DROP;
   end
   // control state: redirect flushes the queue and retargets the fetch PC ahead of any push/pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state <= state_nx;
         if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + 32'd4;
               wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {2'b00, push} - {2'b00, pop};
         end
      end
   end
   // entry storage needs no reset: outputs are masked while the queue is empty
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]  <= fetch_pc;
         fifo_ins[wr_ptr] <= imem_rdata;
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed vector table plus hand-written redirect/reset sequences
module tb_instr_fetch_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic imem_req, imem_rvalid, redirect, instr_valid, instr_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
   logic [2:0] fifo_count;
   int checks = 0;
   int errors = 0;
   int lat = 1;
   int cd = 0;
   logic auto_rsp = 1'b1;
   logic h_rvalid = 1'b0;
   logic [31:0] h_rdata = '0;
   logic m_rvalid;
   logic [31:0] m_rdata, pa;
   logic [31:0] dq_pc[$];
   typedef struct {
      logic rst; logic rdy; logic req; logic [31:0] addr;
      logic v; logic [31:0] pc; logic [31:0] ins; logic [2:0] cnt;
   } vec_t;
   vec_t tbl[$];
   always #5 clk = ~clk;
   assign imem_rvalid = auto_rsp ? m_rvalid : h_rvalid;
   assign imem_rdata  = auto_rsp ? m_rdata : h_rdata;
   instr_fetch_queue dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
      .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .instr_ready(instr_ready), .fifo_count(fifo_count)
   );
   // memory model: answers each request lat cycles later with rdata = addr + 0x100
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rvalid <= 1'b0;
         m_rdata  <= '0;
         cd       <= 0;
      end else begin
         m_rvalid <= 1'b0;
         if (imem_req) begin
            pa <= imem_addr;
            if (lat == 1) begin
               m_rvalid <= 1'b1;
               m_rdata  <= imem_addr + 32'h100;
            end else cd <= lat - 1;
         end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
               m_rvalid <= 1'b1;
               m_rdata  <= pa + 32'h100;
            end
         end
      end
   end
   // delivery log: PCs accepted by the decoder
   always @(posedge clk) begin
      if (rst_n && instr_valid && instr_ready && !redirect) dq_pc.push_back(instr_pc);
   end
   task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, got, exp);
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      auto_rsp = 1'b1; h_rvalid = 1'b0; lat = 1;
      repeat (2) @(negedge clk);
      dq_pc.delete();
      rst_n = 1'b1;
   endtask
   function automatic void add(input logic r, input logic rd, input logic rq, input logic [31:0] a,
                               input logic v, input logic [31:0] p, input logic [31:0] i, input logic [2:0] c);
      tbl.push_back('{r, rd, rq, a, v, p, i, c});
   endfunction
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      // streaming with decoder always ready
      add(1,1,1,32'h0,0,32'h0,32'h0,3'd0);
      add(0,1,0,32'h0,0,32'h0,32'h0,3'd0);
      add(0,1,1,32'h4,1,32'h0,32'h100,3'd1);
      add(0,1,0,32'h0,0,32'h0,32'h0,3'd0);
      add(0,1,1,32'h8,1,32'h4,32'h104,3'd1);
      add(0,1,0,32'h0,0,32'h0,32'h0,3'd0);
      add(0,1,1,32'hC,1,32'h8,32'h108,3'd1);
      add(0,1,0,32'h0,0,32'h0,32'h0,3'd0);
      add(0,1,1,32'h10,1,32'hC,32'h10C,3'd1);
      // decoder stalled until full, then drain with back-to-back refill
      add(1,0,1,32'h0,0,32'h0,32'h0,3'd0);
      add(0,0,0,32'h0,0,32'h0,32'h0,3'd0);
      add(0,0,1,32'h4,1,32'h0,32'h100,3'd1);
      add(0,0,0,32'h0,1,32'h0,32'h100,3'd1);
      add(0,0,1,32'h8,1,32'h0,32'h100,3'd2);
      add(0,0,0,32'h0,1,32'h0,32'h100,3'd2);
      add(0,0,1,32'hC,1,32'h0,32'h100,3'd3);
      add(0,0,0,32'h0,1,32'h0,32'h100,3'd3);
      add(0,0,0,32'h0,1,32'h0,32'h100,3'd4);
      add(0,0,0,32'h0,1,32'h0,32'h100,3'd4);
      add(0,1,1,32'h10,1,32'h0,32'h100,3'd4);
      add(0,1,0,32'h0,1,32'h4,32'h104,3'd3);
      add(0,1,1,32'h14,1,32'h8,32'h108,3'd3);
      add(0,1,0,32'h0,1,32'hC,32'h10C,3'd2);
      add(0,1,1,32'h18,1,32'h10,32'h110,3'd2);
      #12;
      chk("reset", {imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count}, '0);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset(); else @(negedge clk);
         instr_ready = tbl[i].rdy;
         #1;
         chk($sformatf("vec%0d", i), {imem_req, imem_addr, instr_valid, instr_pc, instr, fifo_count},
             {tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].cnt});
      end
      // redirect while waiting on a slow response
      do_reset(); lat = 3; instr_ready = 1'b1; #1;
      chk("s3_req0", {imem_req, imem_addr}, {1'b1, 32'h0});
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'h203; #1;
      chk("s3_redir_noreq", {31'd0, imem_req}, 32'd0);
      @(negedge clk); redirect = 1'b0; #1;
      chk("s3_drop", {imem_req, instr_valid, fifo_count}, {1'b0, 1'b0, 3'd0});
      @(negedge clk); #1;
      chk("s3_stale", {imem_rvalid, imem_req, instr_valid}, {1'b1, 1'b0, 1'b0});
      @(negedge clk); #1;
      chk("s3_refetch", {imem_req, imem_addr}, {1'b1, 32'h200});
      for (int k = 0; k < 12 && !instr_valid; k++) begin @(negedge clk); #1; end
      chk("s3_first", {instr_valid, instr_pc, instr}, {1'b1, 32'h200, 32'h300});
      // redirect colliding with response and pop while two entries are queued
      do_reset();
      repeat (5) @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h1000; instr_ready = 1'b1; #1;
      chk("s4_pre", {imem_rvalid, instr_valid, fifo_count, imem_req}, {1'b1, 1'b1, 3'd2, 1'b0});
      @(negedge clk); redirect = 1'b0; #1;
      chk("s4_post", {instr_valid, fifo_count, imem_req, imem_addr}, {1'b0, 3'd0, 1'b1, 32'h1000});
      chk("s4_nopop", 128'(dq_pc.size()), 128'd0);
      // redirect to the top of the address space, with misaligned low bits
      do_reset(); instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
      chk("s5_noreq", {31'd0, imem_req}, 32'd0);
      @(negedge clk); redirect = 1'b0; #1;
      chk("s5_req", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
      for (int k = 0; k < 20 && dq_pc.size() < 3; k++) @(negedge clk);
      chk("s5_count", 128'(dq_pc.size()), 128'd3);
      if (dq_pc.size() >= 3) chk("s5_wrap", {dq_pc[0], dq_pc[1], dq_pc[2]}, {32'hFFFF_FFFC, 32'h0, 32'h4});
      // asynchronous reset while waiting with three entries queued, then a stale response
      do_reset();
      repeat (6) @(negedge clk);
      auto_rsp = 1'b0; #1;
      chk("s6_c6", {imem_req, imem_addr, fifo_count}, {1'b1, 32'hC, 3'd3});
      @(negedge clk); #1;
      chk("s6_wait", {imem_req, fifo_count, imem_rvalid}, {1'b0, 3'd3, 1'b0});
      #2 rst_n = 1'b0; #1;
      chk("s6_async", {imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count}, '0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; h_rvalid = 1'b1; h_rdata = 32'hDEAD_BEEF; #1;
      chk("s6_restart", {imem_req, imem_addr}, {1'b1, 32'h0});
      @(negedge clk); h_rvalid = 1'b0; #1;
      chk("s6_late_ignored", {imem_req, instr_valid, fifo_count}, {1'b0, 1'b0, 3'd0});
      @(negedge clk); h_rvalid = 1'b1; h_rdata = 32'h1234;
      @(negedge clk); h_rvalid = 1'b0; #1;
      chk("s6_deliver", {instr_valid, instr_pc, instr, fifo_count}, {1'b1, 32'h0, 32'h1234, 3'd1});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
